sm3_unpad_core: RTL and testbench

- Inverse of sm3_pad_core. Consumes a padded SM3 word stream, one or more 512-bit blocks, 32-bit big-endian words.
- Strips the 0x80 marker, the zero fill and the 64-bit length field, and re-emits the original message in the msg_inpt_* format: last beat carries an MSB-first byte mask.
- Used as a loopback checker behind the pad core and as a reference consumer in pad-path benches.

---
 rtl/sm3_pkg.sv | 25 ++
 rtl/sm3_unpad_buf.sv | 63 ++++++
 rtl/sm3_unpad_core.sv | 179 +++++++++++++++++
 tb/tb_sm3_unpad_core.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm3_pkg.sv
// rtl/sm3_pkg.sv - shared SM3 padding types, constants and byte-mask helper
package sm3_pkg;

    typedef enum logic [1:0] {
        STREAM,
        PARSE,
        DRAIN,
        FLUSH
    } unpad_state_e;

    localparam int BLK_WORDS = 16;
    localparam int LEN_WORDS = 2;
    localparam logic [7:0] PAD_MARK = 8'h80;

    // MSB-first valid-byte mask for a final beat holding rem_bytes mod 4 bytes
    function automatic logic [3:0] byte_mask(input logic [1:0] rem_bytes);
        case (rem_bytes)
            2'd1:    byte_mask = 4'b1000;
            2'd2:    byte_mask = 4'b1100;
            2'd3:    byte_mask = 4'b1110;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/sm3_unpad_buf.sv
// rtl/sm3_unpad_buf.sv - circular word buffer with head pop and three offset read taps
module sm3_unpad_buf #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] push_d,
    input  logic          pop,
    output logic [DW-1:0] head_d,
    output logic [AW:0]   count,
    input  logic [AW-1:0] tap_a_off,
    input  logic [AW-1:0] tap_b_off,
    input  logic [AW-1:0] tap_c_off,
    output logic [DW-1:0] tap_a_d,
    output logic [DW-1:0] tap_b_d,
    output logic [DW-1:0] tap_c_d
);

    logic [DW-1:0] mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Pointer arithmetic wraps at DEPTH so non-power-of-two depths still work
    function automatic logic [AW-1:0] wrap(input logic [AW:0] s);
        if (s >= (AW+1)'(DEPTH))
            wrap = AW'(s - (AW+1)'(DEPTH));
        else
            wrap = s[AW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wrap({1'b0, wr_ptr} + (AW+1)'(1));
            if (pop)
                rd_ptr <= wrap({1'b0, rd_ptr} + (AW+1)'(1));
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_d  = mem[rd_ptr];
    assign tap_a_d = mem[wrap({1'b0, rd_ptr} + {1'b0, tap_a_off})];
    assign tap_b_d = mem[wrap({1'b0, rd_ptr} + {1'b0, tap_b_off})];
    assign tap_c_d = mem[wrap({1'b0, rd_ptr} + {1'b0, tap_c_off})];

endmodule

// File: rtl/sm3_unpad_core.sv
// rtl/sm3_unpad_core.sv - strips SM3 padding and re-emits the original message stream
module sm3_unpad_core
    import sm3_pkg::*;
#(
    parameter int DW        = 32,
    parameter int BUF_WORDS = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] pad_otpt_d,
    input  logic          pad_otpt_vld,
    input  logic          pad_otpt_lst,
    output logic          pad_otpt_ena,
    output logic [DW-1:0] msg_otpt_d,
    output logic          msg_otpt_vld,
    output logic [3:0]    msg_otpt_vld_byte,
    output logic          msg_otpt_lst,
    input  logic          msg_otpt_ena,
    output logic          unpad_err
);

    localparam int AW = $clog2(BUF_WORDS);

    unpad_state_e state, state_nxt;

    logic [59:0]   in_words;
    logic [60:0]   out_bytes;
    logic [AW:0]   drain_left;
    logic [1:0]    tail_bytes;
    logic          drain_zero;

    logic [AW:0]   count;
    logic [DW-1:0] head_d;
    logic [DW-1:0] tap_a_d, tap_b_d, tap_c_d;
    logic [AW-1:0] tap_a_off, tap_b_off, tap_c_off;

    logic          full;
    logic          pad_ena_int;
    logic          in_fire;
    logic          out_fire;
    logic          pop;
    logic          msg_vld_int;
    logic          msg_lst_int;
    logic [3:0]    msg_mask_int;
    logic [DW-1:0] msg_d_int;

    logic [63:0]   len_bits;
    logic [60:0]   msg_bytes;
    logic [60:0]   rem_bytes;
    logic [59:0]   rem_words;
    logic [7:0]    mark_byte;
    logic          parse_err;

    assign full        = (count == (AW+1)'(BUF_WORDS));
    assign pad_ena_int = rst_n && (state == STREAM) && (!full || out_fire);
    assign in_fire     = pad_otpt_vld && pad_ena_int;
    assign out_fire    = msg_vld_int && msg_otpt_ena;
    assign pop         = out_fire && !(state == DRAIN && drain_zero);

    // The two newest words hold the length; the marker sits right after the last message byte
    assign tap_a_off = AW'(count - (AW+1)'(LEN_WORDS));
    assign tap_b_off = AW'(count - (AW+1)'(1));
    assign tap_c_off = rem_bytes[AW+1:2];

    assign len_bits  = {tap_a_d, tap_b_d};
    assign msg_bytes = len_bits[63:3];
    assign rem_bytes = msg_bytes - out_bytes;
    assign rem_words = {1'b0, rem_bytes[60:2]} + {59'd0, |rem_bytes[1:0]};

    always_comb begin
        case (rem_bytes[1:0])
            2'd0:    mark_byte = tap_c_d[31:24];
            2'd1:    mark_byte = tap_c_d[23:16];
            2'd2:    mark_byte = tap_c_d[15:8];
            default: mark_byte = tap_c_d[7:0];
        endcase
    end

    assign parse_err = (in_words[$clog2(BLK_WORDS)-1:0] != '0)
                    || (len_bits[2:0] != 3'd0)
                    || (msg_bytes < out_bytes)
                    || (({2'b00, rem_words} + 62'(LEN_WORDS)) > 62'(count))
                    || (mark_byte != PAD_MARK);

    sm3_unpad_buf #(
        .DW    (DW),
        .DEPTH (BUF_WORDS),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (state == FLUSH),
        .push      (in_fire),
        .push_d    (pad_otpt_d),
        .pop       (pop),
        .head_d    (head_d),
        .count     (count),
        .tap_a_off (tap_a_off),
        .tap_b_off (tap_b_off),
        .tap_c_off (tap_c_off),
        .tap_a_d   (tap_a_d),
        .tap_b_d   (tap_b_d),
        .tap_c_d   (tap_c_d)
    );

    always_comb begin
        msg_vld_int  = 1'b0;
        msg_lst_int  = 1'b0;
        msg_mask_int = 4'b0000;
        msg_d_int    = '0;
        case (state)
            STREAM: begin
                msg_vld_int  = full;
                msg_mask_int = 4'b1111;
            end
            DRAIN: begin
                msg_vld_int = 1'b1;
                if (drain_zero) begin
                    msg_lst_int = 1'b1;
                end else begin
                    msg_lst_int  = (drain_left == (AW+1)'(1));
                    msg_mask_int = msg_lst_int ? byte_mask(tail_bytes) : 4'b1111;
                end
            end
            default: ;
        endcase
        for (int i = 0; i < 4; i++)
            msg_d_int[8*i +: 8] = msg_mask_int[i] ? head_d[8*i +: 8] : 8'h00;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            STREAM: if (in_fire && pad_otpt_lst) state_nxt = PARSE;
            PARSE:  state_nxt = parse_err ? FLUSH : DRAIN;
            DRAIN:  if (out_fire && msg_lst_int) state_nxt = FLUSH;
            FLUSH:  state_nxt = STREAM;
            default: state_nxt = STREAM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= STREAM;
            in_words   <= '0;
            out_bytes  <= '0;
            drain_left <= '0;
            tail_bytes <= '0;
            drain_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FLUSH) begin
                in_words  <= '0;
                out_bytes <= '0;
            end else begin
                if (in_fire)
                    in_words <= in_words + 60'd1;
                if (out_fire && state == STREAM)
                    out_bytes <= out_bytes + 61'd4;
            end
            if (state == PARSE) begin
                drain_left <= rem_words[AW:0];
                tail_bytes <= rem_bytes[1:0];
                drain_zero <= (rem_bytes == '0);
            end else if (state == DRAIN && out_fire) begin
                drain_left <= drain_left - (AW+1)'(1);
            end
        end
    end

    // Outputs are forced low while reset is asserted
    assign pad_otpt_ena      = pad_ena_int;
    assign msg_otpt_vld      = rst_n && msg_vld_int;
    assign msg_otpt_lst      = rst_n && msg_lst_int;
    assign msg_otpt_vld_byte = rst_n ? msg_mask_int : 4'b0000;
    assign msg_otpt_d        = rst_n ? msg_d_int : '0;
    assign unpad_err         = rst_n && (state == PARSE) && parse_err;

endmodule

// File: tb/tb_sm3_unpad_core.sv
// tb/tb_sm3_unpad_core.sv - scoreboard bench for sm3_unpad_core
module tb_sm3_unpad_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pad_otpt_d = '0;
    logic        pad_otpt_vld = 1'b0;
    logic        pad_otpt_lst = 1'b0;
    logic        pad_otpt_ena;
    logic [31:0] msg_otpt_d;
    logic        msg_otpt_vld;
    logic [3:0]  msg_otpt_vld_byte;
    logic        msg_otpt_lst;
    logic        msg_otpt_ena = 1'b1;
    logic        unpad_err;

    always #5 clk = ~clk;

    sm3_unpad_core #(.DW(32), .BUF_WORDS(32)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pad_otpt_d        (pad_otpt_d),
        .pad_otpt_vld      (pad_otpt_vld),
        .pad_otpt_lst      (pad_otpt_lst),
        .pad_otpt_ena      (pad_otpt_ena),
        .msg_otpt_d        (msg_otpt_d),
        .msg_otpt_vld      (msg_otpt_vld),
        .msg_otpt_vld_byte (msg_otpt_vld_byte),
        .msg_otpt_lst      (msg_otpt_lst),
        .msg_otpt_ena      (msg_otpt_ena),
        .unpad_err         (unpad_err)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  m;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  msg_q[$];
    logic [31:0] pad_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int err_seen = 0;
    int err_exp  = 0;
    int words_sent = 0;
    int first_beat_words = -1;
    int beats_seen = 0;
    int bytes_seen = 0;
    int stall_cnt = 0;
    bit bp_on = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        msg_otpt_ena = bp_on ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic        prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic [3:0]  prev_m;

    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (unpad_err)
                err_seen++;
            if (prev_stall && msg_otpt_vld) begin
                chk("hold_d", 64'(msg_otpt_d), 64'(prev_d));
                chk("hold_mask", 64'(msg_otpt_vld_byte), 64'(prev_m));
            end
            prev_stall = msg_otpt_vld && !msg_otpt_ena;
            prev_d = msg_otpt_d;
            prev_m = msg_otpt_vld_byte;
            if (msg_otpt_vld && msg_otpt_ena) begin
                if (first_beat_words < 0)
                    first_beat_words = words_sent;
                beats_seen++;
                bytes_seen += $countones(msg_otpt_vld_byte);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got d=%h mask=%b lst=%b expected no beat",
                             msg_otpt_d, msg_otpt_vld_byte, msg_otpt_lst);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_d", 64'(msg_otpt_d), 64'(b.d));
                    chk("beat_mask", 64'(msg_otpt_vld_byte), 64'(b.m));
                    chk("beat_lst", 64'(msg_otpt_lst), 64'(b.l));
                end
            end
        end
    end

    task automatic build_pad();
        logic [7:0]  b[$];
        logic [63:0] len;
        b = msg_q;
        b.push_back(8'h80);
        while (b.size() % 64 != 56)
            b.push_back(8'h00);
        len = 64'(msg_q.size()) * 64'd8;
        for (int i = 7; i >= 0; i--)
            b.push_back(len[8*i +: 8]);
        pad_q.delete();
        for (int i = 0; i < b.size(); i += 4)
            pad_q.push_back({b[i], b[i+1], b[i+2], b[i+3]});
    endtask

    task automatic expect_msg();
        int          n;
        int          k;
        logic [31:0] d;
        logic [3:0]  m;
        beat_t       bt;
        n = msg_q.size();
        if (n == 0) begin
            bt.d = 32'h0; bt.m = 4'b0000; bt.l = 1'b1;
            exp_q.push_back(bt);
        end
        for (int i = 0; i < n; i += 4) begin
            k = (n - i >= 4) ? 4 : n - i;
            d = '0;
            for (int j = 0; j < k; j++)
                d[31-8*j -: 8] = msg_q[i+j];
            m = 4'b1111;
            m = ~(m >> k);
            bt.d = d; bt.m = m; bt.l = (i + 4 >= n);
            exp_q.push_back(bt);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int guard;
        guard = 0;
        pad_otpt_d   = d;
        pad_otpt_vld = 1'b1;
        pad_otpt_lst = l;
        @(negedge clk);
        while (!pad_otpt_ena && guard <= 5000) begin
            if (!bp_on)
                stall_cnt++;
            guard++;
            @(negedge clk);
        end
        if (guard > 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got no pad_otpt_ena expected ready within 5000 cycles");
            pad_otpt_vld = 1'b0;
        end
        @(posedge clk);
        #1;
        if (guard <= 5000)
            words_sent++;
        pad_otpt_vld = 1'b0;
        pad_otpt_lst = 1'b0;
    endtask

    // corrupt: 0 clean, 1 length 0x19, 2 marker 0x00, 3 lst on word 15
    task automatic send_msg(input int corrupt, input int max_words);
        int nw;
        int g;
        int sz;
        build_pad();
        sz = msg_q.size();
        if (corrupt == 1)
            pad_q[pad_q.size()-1] = 32'h0000_0019;
        if (corrupt == 2)
            pad_q[sz/4][31-8*(sz%4) -: 8] = 8'h00;
        nw = (corrupt == 3) ? 15 : pad_q.size();
        if (max_words > 0 && max_words < nw)
            nw = max_words;
        g = 0;
        @(negedge clk);
        while (!pad_otpt_ena && g < 5000) begin
            g++;
            @(negedge clk);
        end
        if (g >= 5000) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: got pad_otpt_ena=0 expected 1");
        end
        @(posedge clk);
        #1;
        stall_cnt = 0;
        words_sent = 0;
        first_beat_words = -1;
        for (int i = 0; i < nw; i++)
            send_word(pad_q[i], (i == nw - 1) && (max_words == 0));
    endtask

    task automatic wait_empty(input string name);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 20000) begin
            g++;
            @(negedge clk);
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, "_pad_ena"}, 64'(pad_otpt_ena), 64'd0);
        chk({name, "_vld"}, 64'(msg_otpt_vld), 64'd0);
        chk({name, "_d"}, 64'(msg_otpt_d), 64'd0);
        chk({name, "_mask"}, 64'(msg_otpt_vld_byte), 64'd0);
        chk({name, "_lst"}, 64'(msg_otpt_lst), 64'd0);
        chk({name, "_err"}, 64'(unpad_err), 64'd0);
    endtask

    task automatic clean_3byte(input string name);
        beat_t bt;
        msg_q = '{8'h01, 8'h02, 8'h03};
        bt.d = 32'h0102_0300; bt.m = 4'b1110; bt.l = 1'b1;
        exp_q.push_back(bt);
        send_msg(0, 0);
        wait_empty(name);
    endtask

    task automatic corrupt_case(input int mode, input string name);
        msg_q = '{8'h01, 8'h02, 8'h03};
        send_msg(mode, 0);
        repeat (4) @(posedge clk);
        #1;
        err_exp++;
        chk(name, 64'(err_seen), 64'(err_exp));
        clean_3byte({name, "_recover"});
    endtask

    initial begin
        beat_t bt;
        int b0;
        int by0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_ena", 64'(pad_otpt_ena), 64'd1);
        @(posedge clk);
        #1;

        clean_3byte("t1_3byte");

        msg_q.delete();
        bt.d = 32'h0; bt.m = 4'b0000; bt.l = 1'b1;
        exp_q.push_back(bt);
        send_msg(0, 0);
        wait_empty("t2_empty");

        msg_q.delete();
        for (int i = 0; i < 14; i++) begin
            msg_q.push_back(8'h01); msg_q.push_back(8'h02);
            msg_q.push_back(8'h03); msg_q.push_back(8'h04);
        end
        expect_msg();
        b0 = beats_seen;
        send_msg(0, 0);
        wait_empty("t3_56byte");
        chk("t3_first_beat_words", 64'(first_beat_words), 64'd32);
        chk("t3_beats", 64'(beats_seen - b0), 64'd14);

        msg_q.delete();
        for (int i = 0; i < 6400; i++)
            msg_q.push_back(8'((i * 7 + 3) ^ (i >> 8)));
        expect_msg();
        b0 = beats_seen;
        by0 = bytes_seen;
        send_msg(0, 0);
        wait_empty("t4_6400");
        chk("t4_first_beat_words", 64'(first_beat_words), 64'd32);
        chk("t4_beats", 64'(beats_seen - b0), 64'd1600);
        chk("t4_bytes", 64'(bytes_seen - by0), 64'd6400);
        chk("t4_stalls", 64'(stall_cnt), 64'd0);

        bp_on = 1'b1;
        msg_q.delete();
        for (int i = 0; i < 1024; i++)
            msg_q.push_back(8'(i * 13 + 5));
        expect_msg();
        b0 = beats_seen;
        send_msg(0, 0);
        wait_empty("t5_backpressure");
        chk("t5_beats", 64'(beats_seen - b0), 64'd256);
        bp_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        corrupt_case(1, "t6_bad_len");
        corrupt_case(2, "t6_bad_mark");
        corrupt_case(3, "t6_early_lst");

        msg_q.delete();
        for (int i = 0; i < 160; i++)
            msg_q.push_back(8'(i));
        send_msg(0, 20);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_reset_ena", 64'(pad_otpt_ena), 64'd1);
        @(posedge clk);
        #1;
        clean_3byte("t7_after_reset");

        repeat (4) @(posedge clk);
        #1;
        chk("err_total", 64'(err_seen), 64'(err_exp));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
